refill_mem_responder: RTL and testbench

Memory-side responder for the I-cache line-refill protocol. It answers a refill initiator that drives mem_req/mem_addr and consumes mem_ack/mem_data. Each response is a single-cycle ack pulse that carries one 32-bit word, after a programmable latency. The block is the backing-memory model, holding a word-addressed RAM with a preload write port, and includes a sticky protocol checker for 4-beat line bursts.

---
 rtl/refill_mem_responder.sv | 149 ++++++++++++++
 tb/tb_refill_mem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/refill_mem_responder.sv
// Backing-memory responder for I-cache line refills: one ack pulse per beat after LATENCY idle cycles,
// a preload write port, and a sticky checker for aligned, sequential BEATS-word bursts.
module refill_mem_responder #(
    parameter int XLEN      = 32,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2,
    parameter int BEATS     = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_req,
    input  logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_data,
    output logic            mem_ack,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic            busy,
    output logic            seq_err
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = $clog2(BEATS) + 1;
    localparam logic [3:0]    LAT_LOAD  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic          LAT_ZERO  = (LATENCY == 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_GAP} state_t;

    state_t          r_state, r_state_next;
    logic [3:0]      r_cnt, r_cnt_next;
    logic [BW-1:0]   r_beat, r_beat_next;
    logic [XLEN-1:0] r_prev_addr, r_prev_addr_next;
    logic            r_err_next;
    logic            w_enter_ack;

    logic [XLEN-1:0] r_mem [MEM_WORDS];
    logic [AW-1:0]   w_rd_idx;
    logic [AW-1:0]   w_wr_idx;
    logic            w_unused_wr;

    assign w_rd_idx    = mem_addr[AW+1:2];
    assign w_wr_idx    = wr_addr[AW+1:2];
    assign w_unused_wr = ^{wr_addr[XLEN-1:AW+2], wr_addr[1:0]};
    assign busy        = (r_state != S_IDLE);

    // RAM contents survive reset; preload is legal at any time.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[w_wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_beat      <= '0;
            r_prev_addr <= '0;
            seq_err     <= 1'b0;
            mem_ack     <= 1'b0;
            mem_data    <= '0;
        end else begin
            r_state     <= r_state_next;
            r_cnt       <= r_cnt_next;
            r_beat      <= r_beat_next;
            r_prev_addr <= r_prev_addr_next;
            seq_err     <= r_err_next;
            mem_ack     <= w_enter_ack;
            // A same-edge preload is not yet visible here, so the old word is returned.
            if (w_enter_ack) begin
                mem_data <= r_mem[w_rd_idx];
            end
        end
    end

    always_comb begin
        r_state_next     = r_state;
        r_cnt_next       = r_cnt;
        r_beat_next      = r_beat;
        r_prev_addr_next = r_prev_addr;
        r_err_next       = seq_err;
        w_enter_ack      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (mem_req) begin
                    r_beat_next = '0;
                    if (LAT_ZERO) begin
                        r_state_next = S_ACK;
                        w_enter_ack  = 1'b1;
                    end else begin
                        r_state_next = S_WAIT;
                        r_cnt_next   = LAT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!mem_req) begin
                    r_state_next = S_IDLE;
                    r_beat_next  = '0;
                    r_err_next   = 1'b1;
                end else if (r_cnt == 4'd0) begin
                    r_state_next = S_ACK;
                    w_enter_ack  = 1'b1;
                end else begin
                    r_cnt_next = r_cnt - 4'd1;
                end
            end
            S_ACK: begin
                r_state_next = S_GAP;
            end
            S_GAP: begin
                if (!mem_req) begin
                    r_state_next = S_IDLE;
                    r_beat_next  = '0;
                end else begin
                    if (r_beat == LAST_BEAT) begin
                        r_err_next = 1'b1;
                    end
                    r_beat_next = r_beat + BW'(1);
                    if (LAT_ZERO) begin
                        r_state_next = S_ACK;
                        w_enter_ack  = 1'b1;
                    end else begin
                        r_state_next = S_WAIT;
                        r_cnt_next   = LAT_LOAD;
                    end
                end
            end
            default: begin
                r_state_next = S_IDLE;
            end
        endcase

        // Address checks happen on the same edge the beat is captured.
        if (w_enter_ack) begin
            r_prev_addr_next = mem_addr;
            if (r_beat_next == '0) begin
                if (mem_addr[3:0] != 4'd0) begin
                    r_err_next = 1'b1;
                end
            end else if (mem_addr != r_prev_addr + XLEN'(4)) begin
                r_err_next = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_refill_mem_responder.sv
// Scoreboard bench: one responder with LATENCY=2 and one with LATENCY=0 share the preload port;
// expected acks (cycle, data) are queued when a burst starts and popped as acks appear.
module tb_refill_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req     [2];
    logic [31:0] addr    [2];
    logic [31:0] rdata   [2];
    logic        ack     [2];
    logic        busy    [2];
    logic        err     [2];
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [1024];
    int          n_vec  = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    refill_mem_responder #(.XLEN(32), .MEM_WORDS(1024), .LATENCY(2), .BEATS(4)) u_dut_l2 (
        .clk(clk), .reset(reset), .mem_req(req[0]), .mem_addr(addr[0]),
        .mem_data(rdata[0]), .mem_ack(ack[0]), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy[0]), .seq_err(err[0])
    );

    refill_mem_responder #(.XLEN(32), .MEM_WORDS(1024), .LATENCY(0), .BEATS(4)) u_dut_l0 (
        .clk(clk), .reset(reset), .mem_req(req[1]), .mem_addr(addr[1]),
        .mem_data(rdata[1]), .mem_ack(ack[1]), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy[1]), .seq_err(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem[a[11:2]];
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        model_mem[a[11:2]] = d;
    endtask

    // Called at a negedge; that cycle is cycle 0 of the burst.
    task automatic run_burst(input int k, input logic [31:0] base, input int n_exp,
                             input int abort_cyc, input int wr_cyc,
                             input logic [31:0] wa, input logic [31:0] wd, input logic exp_err);
        int   lat      = (k == 0) ? 2 : 0;
        int   cyc      = 0;
        int   last_ack = -1;
        int   n_seen   = 0;
        int   end_cyc;
        logic prev_ack = 1'b0;
        exp_t e;
        for (int i = 0; i < n_exp; i++) begin
            e.cyc  = lat + 1 + i * (lat + 2);
            e.data = model_rd(base + 32'(4 * i));
            sb.push_back(e);
        end
        end_cyc = (abort_cyc >= 0) ? abort_cyc + 6 : lat + 1 + (n_exp - 1) * (lat + 2) + 2;
        req[k]  = 1'b1;
        addr[k] = base;
        while (cyc < end_cyc) begin
            @(negedge clk);
            cyc++;
            if (wr_cyc >= 0 && cyc == wr_cyc + 1) begin
                wr_en = 1'b0;
                model_mem[wa[11:2]] = wd;
            end
            if (cyc == wr_cyc) begin
                wr_en   = 1'b1;
                wr_addr = wa;
                wr_data = wd;
            end
            if (last_ack >= 0 && cyc == last_ack + 1) begin
                if (n_seen == n_exp && abort_cyc < 0) req[k] = 1'b0;
                else addr[k] = addr[k] + 32'd4;
            end
            if (cyc == abort_cyc) req[k] = 1'b0;
            if (ack[k]) begin
                $display("ack inst=%0d cyc=%0d data=%h", k, cyc, rdata[k]);
                chk("ack_adjacent", 32'(prev_ack), 32'd0);
                if (sb.size() == 0) begin
                    chk("extra_ack", 32'(ack[k]), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_cycle", cyc, e.cyc);
                    chk("ack_data", rdata[k], e.data);
                end
                last_ack = cyc;
                n_seen++;
            end
            prev_ack = ack[k];
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) chk("busy_after_abort", 32'(busy[k]), 32'd0);
        end
        chk("busy_end", 32'(busy[k]), 32'd0);
        chk("seq_err", 32'(err[k]), 32'(exp_err));
        chk("missing_acks", sb.size(), 32'd0);
        sb.delete();
        req[k] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int k = 0; k < 2; k++) begin
            req[k]  = 1'b0;
            addr[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_data", rdata[k], 32'd0);
            chk("rst_ack", 32'(ack[k]), 32'd0);
            chk("rst_busy", 32'(busy[k]), 32'd0);
            chk("rst_seq_err", 32'(err[k]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) preload(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));

        // Clean bursts: LATENCY=2 then LATENCY=0.
        run_burst(0, 32'h100, 4, -1, -1, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        run_burst(1, 32'h100, 4, -1, -1, 32'h0, 32'h0, 1'b0);
        @(negedge clk);

        // Asynchronous reset while the LATENCY=2 responder waits.
        req[0]  = 1'b1;
        addr[0] = 32'h100;
        @(negedge clk);
        chk("busy_pre_reset", 32'(busy[0]), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_ack", 32'(ack[0]), 32'd0);
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
        chk("rst_mid_data", rdata[0], 32'd0);
        req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Preload collides with beat-2 capture: old word returned, new word seen next burst.
        run_burst(0, 32'h100, 4, -1, 10, 32'h108, 32'hBEEF, 1'b0);
        @(negedge clk);
        run_burst(0, 32'h100, 4, -1, -1, 32'h0, 32'h0, 1'b0);
        @(negedge clk);

        // Abort during WAIT of beat 1.
        run_burst(0, 32'h100, 1, 5, -1, 32'h0, 32'h0, 1'b1);
        @(negedge clk);

        // Misaligned beat-0 address on the LATENCY=0 responder.
        run_burst(1, 32'h104, 4, -1, -1, 32'h0, 32'h0, 1'b1);
        repeat (3) @(negedge clk);
        chk("seq_err_sticky", 32'(err[1]), 32'd1);
        chk("seq_err_sticky_l2", 32'(err[0]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
